// File: rtl/heap_pq.sv
// rtl/heap_pq.sv - parametrised binary-heap priority queue (min or max)
module heap_pq #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int MAXHEAP = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] size,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic          done,
  output logic          valid,
  output logic          err
);
  localparam int DEPTH = (1 << AW) - 1;
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0] ONE_X = {{AW{1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_UP_RD   = 3'd1;
  localparam logic [2:0] S_UP_CMP  = 3'd2;
  localparam logic [2:0] S_DN_LAST = 3'd3;
  localparam logic [2:0] S_DN_RDL  = 3'd4;
  localparam logic [2:0] S_DN_RDR  = 3'd5;
  localparam logic [2:0] S_DN_CMP  = 3'd6;
  localparam logic [2:0] S_FIN     = 3'd7;

  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic [DW-1:0] key;
  logic [DW-1:0] par;
  logic [DW-1:0] lc;
  logic [DW-1:0] rc;
  logic          has_r;
  logic [DW-1:0] mem [1:DEPTH];

  logic [AW:0]   l2;
  logic [AW:0]   r2;
  logic [AW:0]   n_ext;
  logic          r_sel;
  logic          key_up;
  logic          c_wins;
  logic [DW-1:0] cval;
  logic [AW-1:0] cidx;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_val;
  logic [DW-1:0] wd;
  logic          we;

  function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (MAXHEAP != 0) ? (a > b) : (a < b);
  endfunction

  // Child indices carry an extra bit so 2i+1 never wraps at the bottom level.
  always_comb begin
    l2     = {idx, 1'b0};
    r2     = l2 + ONE_X;
    n_ext  = {1'b0, size};
    r_sel  = has_r && better(rc, lc);
    cval   = r_sel ? rc : lc;
    cidx   = r_sel ? r2[AW-1:0] : l2[AW-1:0];
    key_up = better(key, par);
    c_wins = better(cval, key);
  end

  always_comb begin
    rd_addr = ONE;
    case (state)
      S_UP_RD:   rd_addr = idx >> 1;
      S_DN_LAST: rd_addr = size + ONE;
      S_DN_RDL:  rd_addr = (l2 <= n_ext) ? l2[AW-1:0] : ONE;
      S_DN_RDR:  rd_addr = (r2 <= n_ext) ? r2[AW-1:0] : ONE;
      default:   rd_addr = ONE;
    endcase
  end

  assign rd_val = mem[rd_addr];

  // The hole at idx is filled either by the moving element or by the key itself.
  always_comb begin
    we = 1'b0;
    wd = key;
    case (state)
      S_UP_RD:  we = (idx == ONE);
      S_UP_CMP: begin
        we = 1'b1;
        if (key_up) wd = par;
      end
      S_DN_RDL: we = (l2 > n_ext);
      S_DN_CMP: begin
        we = 1'b1;
        if (c_wins) wd = cval;
      end
      default:  we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      size  <= '0;
      dout  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      idx   <= '0;
      key   <= '0;
      par   <= '0;
      lc    <= '0;
      rc    <= '0;
      has_r <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state != S_IDLE && (push || pop)) err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (push && pop && !empty) begin
            key   <= din;
            idx   <= ONE;
            state <= S_DN_RDL;
          end else if (push) begin
            if (full) begin
              err <= 1'b1;
            end else begin
              size  <= size + ONE;
              key   <= din;
              idx   <= size + ONE;
              state <= S_UP_RD;
            end
          end else if (pop) begin
            if (empty) begin
              err <= 1'b1;
            end else begin
              size  <= size - ONE;
              state <= S_DN_LAST;
            end
          end
        end
        S_UP_RD: begin
          if (idx == ONE) begin
            state <= S_FIN;
          end else begin
            par   <= rd_val;
            state <= S_UP_CMP;
          end
        end
        S_UP_CMP: begin
          if (key_up) begin
            idx   <= idx >> 1;
            state <= S_UP_RD;
          end else begin
            state <= S_FIN;
          end
        end
        S_DN_LAST: begin
          key   <= rd_val;
          idx   <= ONE;
          state <= (size == '0) ? S_FIN : S_DN_RDL;
        end
        S_DN_RDL: begin
          if (l2 > n_ext) begin
            state <= S_FIN;
          end else begin
            lc    <= rd_val;
            state <= S_DN_RDR;
          end
        end
        S_DN_RDR: begin
          has_r <= (r2 <= n_ext);
          rc    <= rd_val;
          state <= S_DN_CMP;
        end
        S_DN_CMP: begin
          if (c_wins) begin
            idx   <= cidx;
            state <= S_DN_RDL;
          end else begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          if (size != '0) dout <= rd_val;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign full  = (size == {AW{1'b1}});
  assign empty = (size == '0);
  assign valid = ~empty & ~busy;

endmodule

// File: tb/tb_heap_pq.sv
// tb/tb_heap_pq.sv - randomized and directed bench for heap_pq against a multiset model
module tb_heap_pq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [2:0]      push_v;
  logic [2:0]      pop_v;
  logic [2:0][7:0] din_v;
  logic [2:0][7:0] dout_v;
  logic [7:0]      size0;
  logic [7:0]      size1;
  logic [2:0]      size2;
  logic [2:0]      full_v, empty_v, busy_v, done_v, valid_v, err_v;

  int checks = 0;
  int errors = 0;
  int cnt [3][256];
  int msz [3];

  heap_pq #(.DW(8), .AW(8), .MAXHEAP(0)) u_min (
    .clk(clk), .reset(reset), .push(push_v[0]), .pop(pop_v[0]), .din(din_v[0]),
    .dout(dout_v[0]), .size(size0), .full(full_v[0]), .empty(empty_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .valid(valid_v[0]), .err(err_v[0]));
  heap_pq #(.DW(8), .AW(8), .MAXHEAP(1)) u_max (
    .clk(clk), .reset(reset), .push(push_v[1]), .pop(pop_v[1]), .din(din_v[1]),
    .dout(dout_v[1]), .size(size1), .full(full_v[1]), .empty(empty_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .valid(valid_v[1]), .err(err_v[1]));
  heap_pq #(.DW(8), .AW(3), .MAXHEAP(0)) u_small (
    .clk(clk), .reset(reset), .push(push_v[2]), .pop(pop_v[2]), .din(din_v[2]),
    .dout(dout_v[2]), .size(size2), .full(full_v[2]), .empty(empty_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .valid(valid_v[2]), .err(err_v[2]));

  function automatic int get_size(input int k);
    if (k == 0) return int'(size0);
    if (k == 1) return int'(size1);
    return int'(size2);
  endfunction

  function automatic int cap_of(input int k);
    return (k == 2) ? 7 : 255;
  endfunction

  // Top of the multiset: largest key for the max instance, smallest otherwise.
  function automatic int m_top(input int k);
    if (k == 1) begin
      for (int v = 255; v >= 0; v--) if (cnt[k][v] > 0) return v;
    end else begin
      for (int v = 0; v < 256; v++) if (cnt[k][v] > 0) return v;
    end
    return -1;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 3; k++) begin
      msz[k] = 0;
      for (int v = 0; v < 256; v++) cnt[k][v] = 0;
    end
  endtask

  task automatic m_apply(input int k, input bit p, input bit q, input logic [7:0] d,
                         output bit exp_err, output int bound);
    int aw;
    int t;
    aw = (k == 2) ? 3 : 8;
    exp_err = 1'b0;
    bound = 0;
    if (p && q && msz[k] > 0) begin
      t = m_top(k);
      cnt[k][t]--;
      cnt[k][d]++;
      bound = 3 * aw + 3;
    end else if (p) begin
      if (msz[k] == cap_of(k)) exp_err = 1'b1;
      else begin
        cnt[k][d]++;
        msz[k]++;
        bound = 2 * aw + 2;
      end
    end else if (q) begin
      if (msz[k] == 0) exp_err = 1'b1;
      else begin
        t = m_top(k);
        cnt[k][t]--;
        msz[k]--;
        bound = 3 * aw + 3;
      end
    end
  endtask

  // Issue one command from idle; report err seen after accept, done seen, and latency in cycles.
  task automatic do_op(input int k, input bit p, input bit q, input logic [7:0] d,
                       output bit got_err, output bit got_done, output int lat);
    int lim;
    @(negedge clk);
    push_v[k] = p;
    pop_v[k]  = q;
    din_v[k]  = d;
    @(negedge clk);
    push_v[k] = 1'b0;
    pop_v[k]  = 1'b0;
    got_err  = err_v[k];
    got_done = 1'b0;
    lat = 0;
    lim = got_err ? 4 : 60;
    for (int e = 1; e <= lim; e++) begin
      if (done_v[k]) begin
        got_done = 1'b1;
        lat = e + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    push_v = '0;
    pop_v  = '0;
    din_v  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (get_size(k) != 0) begin
        errors++; $display("FAIL reset_size[%0d]: got %0d expected 0", k, get_size(k));
      end
      checks++;
      if (dout_v[k] !== 8'd0) begin
        errors++; $display("FAIL reset_dout[%0d]: got %0d expected 0", k, dout_v[k]);
      end
      checks++;
      if ({busy_v[k], done_v[k], err_v[k], empty_v[k], full_v[k], valid_v[k]} !== 6'b000100) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got %b expected 000100 (busy done err empty full valid)",
                 k, {busy_v[k], done_v[k], err_v[k], empty_v[k], full_v[k], valid_v[k]});
      end
    end
  endtask

  task automatic test_order(input int k);
    int pv [4];
    int tops [4];
    int pops [4];
    bit ee, ge, gd;
    int bound, lat;
    pv = '{5, 3, 8, 1};
    if (k == 1) begin
      tops = '{5, 5, 8, 8};
      pops = '{8, 5, 3, 1};
    end else begin
      tops = '{5, 3, 3, 1};
      pops = '{1, 3, 5, 8};
    end
    for (int i = 0; i < 4; i++) begin
      m_apply(k, 1'b1, 1'b0, 8'(pv[i]), ee, bound);
      do_op(k, 1'b1, 1'b0, 8'(pv[i]), ge, gd, lat);
      checks++;
      if (!gd || ge || lat > bound) begin
        errors++; $display("FAIL order_push_done[%0d.%0d]: done=%0d err=%0d lat=%0d expected done=1 err=0 lat<=%0d", k, i, gd, ge, lat, bound);
      end
      checks++;
      if (dout_v[k] !== 8'(tops[i])) begin
        errors++; $display("FAIL order_push_top[%0d.%0d]: got %0d expected %0d", k, i, dout_v[k], tops[i]);
      end
    end
    checks++;
    if (get_size(k) != 4) begin
      errors++; $display("FAIL order_size[%0d]: got %0d expected 4", k, get_size(k));
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout_v[k] !== 8'(pops[i])) begin
        errors++; $display("FAIL order_pop_top[%0d.%0d]: got %0d expected %0d", k, i, dout_v[k], pops[i]);
      end
      m_apply(k, 1'b0, 1'b1, 8'd0, ee, bound);
      do_op(k, 1'b0, 1'b1, 8'd0, ge, gd, lat);
      checks++;
      if (!gd || lat > bound) begin
        errors++; $display("FAIL order_pop_done[%0d.%0d]: done=%0d lat=%0d expected done=1 lat<=%0d", k, i, gd, lat, bound);
      end
    end
    checks++;
    if (get_size(k) != 0 || empty_v[k] !== 1'b1) begin
      errors++; $display("FAIL order_final[%0d]: size=%0d empty=%0d expected size=0 empty=1", k, get_size(k), empty_v[k]);
    end
  endtask

  task automatic test_full_err();
    bit ee, ge, gd;
    int bound, lat;
    logic [7:0] d;
    for (int i = 0; i < 7; i++) begin
      d = 8'($urandom_range(0, 255));
      m_apply(2, 1'b1, 1'b0, d, ee, bound);
      do_op(2, 1'b1, 1'b0, d, ge, gd, lat);
      checks++;
      if (!gd || lat > bound) begin
        errors++; $display("FAIL fill_done[%0d]: done=%0d lat=%0d expected done=1 lat<=%0d", i, gd, lat, bound);
      end
    end
    checks++;
    if (full_v[2] !== 1'b1 || get_size(2) != 7) begin
      errors++; $display("FAIL fill_full: full=%0d size=%0d expected full=1 size=7", full_v[2], get_size(2));
    end
    m_apply(2, 1'b1, 1'b0, 8'd99, ee, bound);
    do_op(2, 1'b1, 1'b0, 8'd99, ge, gd, lat);
    checks++;
    if (!ge || gd || get_size(2) != 7) begin
      errors++; $display("FAIL push_full: err=%0d done=%0d size=%0d expected err=1 done=0 size=7", ge, gd, get_size(2));
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (dout_v[2] !== 8'(m_top(2))) begin
        errors++; $display("FAIL drain_top[%0d]: got %0d expected %0d", i, dout_v[2], m_top(2));
      end
      m_apply(2, 1'b0, 1'b1, 8'd0, ee, bound);
      do_op(2, 1'b0, 1'b1, 8'd0, ge, gd, lat);
    end
    m_apply(2, 1'b0, 1'b1, 8'd0, ee, bound);
    do_op(2, 1'b0, 1'b1, 8'd0, ge, gd, lat);
    checks++;
    if (!ge || gd || get_size(2) != 0) begin
      errors++; $display("FAIL pop_empty: err=%0d done=%0d size=%0d expected err=1 done=0 size=0", ge, gd, get_size(2));
    end
  endtask

  task automatic test_replace();
    bit ee, ge, gd;
    int bound, lat;
    int pv [3];
    int exp_pop [3];
    pv = '{2, 4, 6};
    exp_pop = '{4, 5, 6};
    for (int i = 0; i < 3; i++) begin
      m_apply(0, 1'b1, 1'b0, 8'(pv[i]), ee, bound);
      do_op(0, 1'b1, 1'b0, 8'(pv[i]), ge, gd, lat);
    end
    m_apply(0, 1'b1, 1'b1, 8'd5, ee, bound);
    do_op(0, 1'b1, 1'b1, 8'd5, ge, gd, lat);
    checks++;
    if (!gd || ge || lat > bound) begin
      errors++; $display("FAIL replace_done: done=%0d err=%0d lat=%0d expected done=1 err=0 lat<=%0d", gd, ge, lat, bound);
    end
    checks++;
    if (get_size(0) != 3 || dout_v[0] !== 8'd4) begin
      errors++; $display("FAIL replace_result: size=%0d dout=%0d expected size=3 dout=4", get_size(0), dout_v[0]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dout_v[0] !== 8'(exp_pop[i])) begin
        errors++; $display("FAIL replace_pop[%0d]: got %0d expected %0d", i, dout_v[0], exp_pop[i]);
      end
      m_apply(0, 1'b0, 1'b1, 8'd0, ee, bound);
      do_op(0, 1'b0, 1'b1, 8'd0, ge, gd, lat);
    end
  endtask

  task automatic test_busy_cmd();
    bit ee, ge, gd;
    int bound, lat;
    bit seen;
    @(negedge clk);
    push_v[0] = 1'b1;
    din_v[0]  = 8'd10;
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b1) begin
      errors++; $display("FAIL busy_rise: got %0d expected 1", busy_v[0]);
    end
    din_v[0] = 8'd20;
    @(negedge clk);
    push_v[0] = 1'b0;
    checks++;
    if (err_v[0] !== 1'b1) begin
      errors++; $display("FAIL busy_err: got %0d expected 1", err_v[0]);
    end
    seen = 1'b0;
    for (int e = 0; e < 20 && !seen; e++) begin
      if (done_v[0]) seen = 1'b1;
      else @(negedge clk);
    end
    m_apply(0, 1'b1, 1'b0, 8'd10, ee, bound);
    checks++;
    if (!seen || get_size(0) != 1 || dout_v[0] !== 8'd10) begin
      errors++; $display("FAIL busy_ignored: done=%0d size=%0d dout=%0d expected done=1 size=1 dout=10", seen, get_size(0), dout_v[0]);
    end
    m_apply(0, 1'b0, 1'b1, 8'd0, ee, bound);
    do_op(0, 1'b0, 1'b1, 8'd0, ge, gd, lat);
    m_apply(0, 1'b1, 1'b1, 8'd9, ee, bound);
    do_op(0, 1'b1, 1'b1, 8'd9, ge, gd, lat);
    checks++;
    if (ge || !gd || get_size(0) != 1 || dout_v[0] !== 8'd9) begin
      errors++; $display("FAIL both_on_empty: err=%0d done=%0d size=%0d dout=%0d expected err=0 done=1 size=1 dout=9", ge, gd, get_size(0), dout_v[0]);
    end
    m_apply(0, 1'b0, 1'b1, 8'd0, ee, bound);
    do_op(0, 1'b0, 1'b1, 8'd0, ge, gd, lat);
  endtask

  task automatic test_reset_mid();
    bit ee, ge, gd;
    int bound, lat;
    int pv [6];
    pv = '{40, 10, 60, 30, 50, 20};
    for (int i = 0; i < 6; i++) begin
      m_apply(0, 1'b1, 1'b0, 8'(pv[i]), ee, bound);
      do_op(0, 1'b1, 1'b0, 8'(pv[i]), ge, gd, lat);
    end
    @(negedge clk);
    pop_v[0] = 1'b1;
    @(negedge clk);
    pop_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got %0d expected 1", busy_v[0]);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (get_size(0) != 0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++; $display("FAIL mid_reset: size=%0d busy=%0d done=%0d expected 0 0 0", get_size(0), busy_v[0], done_v[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    m_clear();
    m_apply(0, 1'b1, 1'b0, 8'd7, ee, bound);
    do_op(0, 1'b1, 1'b0, 8'd7, ge, gd, lat);
    checks++;
    if (!gd || get_size(0) != 1 || dout_v[0] !== 8'd7) begin
      errors++; $display("FAIL after_reset_push: done=%0d size=%0d dout=%0d expected 1 1 7", gd, get_size(0), dout_v[0]);
    end
    m_apply(0, 1'b0, 1'b1, 8'd0, ee, bound);
    do_op(0, 1'b0, 1'b1, 8'd0, ge, gd, lat);
  endtask

  task automatic test_soak(input int k, input int nops);
    bit p, q, ee, ge, gd;
    int bound, lat, r;
    logic [7:0] d;
    for (int n = 0; n < nops; n++) begin
      r = $urandom_range(0, 99);
      p = (r < 50) || (r >= 85);
      q = (r >= 50);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      m_apply(k, p, q, d, ee, bound);
      do_op(k, p, q, d, ge, gd, lat);
      checks++;
      if (ge !== ee) begin
        errors++; $display("FAIL soak_err[%0d.%0d]: got %0d expected %0d", k, n, ge, ee);
      end
      checks++;
      if (gd !== !ee) begin
        errors++; $display("FAIL soak_done[%0d.%0d]: got %0d expected %0d", k, n, gd, !ee);
      end
      if (gd) begin
        checks++;
        if (lat > bound) begin
          errors++; $display("FAIL soak_latency[%0d.%0d]: got %0d expected <=%0d", k, n, lat, bound);
        end
        checks++;
        if (get_size(k) != msz[k]) begin
          errors++; $display("FAIL soak_size[%0d.%0d]: got %0d expected %0d", k, n, get_size(k), msz[k]);
        end
        checks++;
        if (empty_v[k] !== (msz[k] == 0) || full_v[k] !== (msz[k] == cap_of(k)) || valid_v[k] !== (msz[k] != 0)) begin
          errors++; $display("FAIL soak_flags[%0d.%0d]: empty=%0d full=%0d valid=%0d size_expected=%0d", k, n, empty_v[k], full_v[k], valid_v[k], msz[k]);
        end
        if (msz[k] > 0) begin
          checks++;
          if (dout_v[k] !== 8'(m_top(k))) begin
            errors++; $display("FAIL soak_top[%0d.%0d]: got %0d expected %0d", k, n, dout_v[k], m_top(k));
          end
        end
      end
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_order(0);
    test_order(1);
    test_full_err();
    test_replace();
    test_busy_cmd();
    test_reset_mid();
    test_soak(0, 1000);
    test_soak(1, 1000);
    test_soak(2, 300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
